dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-back, write-allocate data cache that answers the MEM-stage load/store port and issues whole-line reads and writebacks to physical memory. The MEM stage drives the request; this block returns `mem_resp` and `mem_rdata`. Stall logic uses `mem_resp` as `stall_mem = (mem_read | mem_write) & ~mem_resp`. Hits complete in the request cycle. Misses run a writeback/fill sequence against a 256-bit line memory port.

## Interface
- `S_INDEX`, default 4: index bits; the cache has 2^S_INDEX sets of one 256-bit line each.
- Derived: offset = 5 bits; tag width = 27 − S_INDEX.
- `clk` in 1: single clock; all state is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_read` in 1: load request from the MEM stage.
- `mem_write` in 1: store request from the MEM stage.
- `mem_address` in 32: word-aligned address; bits [1:0] are ignored.
- `mem_wdata` in 32: store data, already lane-shifted.
- `mem_byte_enable` in 4: store byte mask.
- `mem_rdata` out 32: the addressed word, valid when `mem_resp` is 1.
- `mem_resp` out 1: request complete this cycle.
- `pmem_read` out 1: line fill request.
- `pmem_write` out 1: line writeback request.
- `pmem_address` out 32: line-aligned address; bits [4:0] are 0.
- `pmem_wdata` out 256: victim line.
- `pmem_rdata` in 256: fill line.
- `pmem_resp` in 1: memory transaction done.

## Operation
- Address fields:
  - tag = `mem_address[31:5+S_INDEX]`
  - index = `mem_address[4+S_INDEX:5]`
  - word select = `mem_address[4:2]`; word w is bits [32w+31:32w] of the line.
- Per-set state: `valid`, `dirty`, tag, 256-bit data. `valid` and `dirty` are flops cleared by reset. Tag and data arrays are not reset.
- States:
  - IDLE: compare request against the indexed set.
  - WRITEBACK: `pmem_write`=1; `pmem_address` = {stored tag, index, 5'b0}; `pmem_wdata` = stored line.
  - FILL: `pmem_read`=1; `pmem_address` = {request tag, index, 5'b0}.
- Hit = request & valid & (stored tag == request tag).
- IDLE, hit, load: `mem_resp`=1, `mem_rdata` = selected word.
- IDLE, hit, store:
  - `mem_resp`=1.
  - At the clock edge, bytes of the selected word with `mem_byte_enable[i]`=1 are replaced by `mem_wdata[8i+7:8i]`.
  - `dirty` is set if the mask is nonzero. A mask of 0000 changes nothing and leaves `dirty` unchanged.
- IDLE, miss: `mem_resp`=0.
  - Next state is WRITEBACK if valid & dirty, else FILL.
- WRITEBACK: hold until `pmem_resp`=1, then go to FILL.
- FILL: hold until `pmem_resp`=1. At that edge:
  - data ← `pmem_rdata`, tag ← request tag, `valid`=1, `dirty`=0.
  - Next state is IDLE, where the request now hits and completes.
- Both `mem_read` and `mem_write` high: treated as a store.
- No request: `mem_resp`=0 and `mem_rdata`=0. No state change.
- The requester holds `mem_read`, `mem_write`, `mem_address`, `mem_wdata` and `mem_byte_enable` stable from assertion until the cycle `mem_resp`=1. The cache does not latch the request.
- `pmem_resp` in IDLE is ignored.

## Timing
- Reset values: state=IDLE, all `valid`/`dirty`=0.
- Outputs under reset: `mem_resp`=0, `mem_rdata`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0.
- Hit latency is 0 cycles: `mem_resp` is combinational in the request cycle.
- Clean miss: `mem_resp` rises 1 cycle after the `pmem_resp` edge that ends FILL.
- Dirty miss: WRITEBACK duration + FILL duration + 1 cycle.
- `pmem_read` and `pmem_write` are Moore outputs of the state, never both high. Each is held continuously until `pmem_resp` is sampled high, and drops in the next cycle.
- A new memory transaction may start in the cycle after `pmem_resp`: WRITEBACK→FILL is back-to-back.
- Reset asserted mid-WRITEBACK or mid-FILL: strobes drop immediately (asynchronously). The transaction is abandoned and the cache comes up empty. A late `pmem_resp` after reset is ignored.
- Back-to-back hits to different sets: one per cycle, no bubbles.
- A store hit followed next cycle by a load to the same word returns the merged data.

## Test plan
- Reset, then load 0x0000_1004 with memory line = {8{0xA5A5_0000 + w}} (w = word index) → `pmem_read` with `pmem_address`=0x0000_1000. After `pmem_resp`, `mem_resp` comes 1 cycle later with `mem_rdata`=0xA5A5_0001.
- Store 0x0000_1008 with `mem_wdata`=0x0000_BE00 and mask 0010 → same-cycle `mem_resp`. Then load 0x0000_1008 → 0xA5A5_BE02. Dirty bit = 1.
- Load 0x0000_1208 (same index, new tag, S_INDEX=4) → WRITEBACK at 0x0000_1000 with word 2 = 0xA5A5_BE02, then FILL at 0x0000_1200. Total = memory latencies + 1 cycle.
- Clean eviction: load 0x0000_2000 after a clean fill of index 0 → no `pmem_write`, FILL only.
- Assert reset while `pmem_read`=1 → `pmem_read`=0 immediately. Next load to the same line misses again.
- Store with mask 0000 on a clean hit → `mem_resp`=1, data unchanged. A later eviction of that line performs no writeback.

Source files
------------

// File: rtl/dcache_if.sv
// Bundles the MEM-stage load/store port and the 256-bit line memory port of the data cache.
// master = requester/memory side, slave = the cache.
interface dcache_if;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [31:0]  mem_wdata;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_rdata;
   logic         mem_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      input  mem_rdata, mem_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      output mem_rdata, mem_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache: same-cycle hits and
// writeback/fill of whole 256-bit lines on a miss.
module dcache #(
   parameter int unsigned S_INDEX = 4
) (
   input logic     clk,
   input logic     rst,
   dcache_if.slave bus
);
   localparam int unsigned SETS  = 1 << S_INDEX;
   localparam int unsigned TAG_W = 27 - S_INDEX;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

   state_t             state, state_next;
   logic [SETS-1:0]    valid, dirty;
   logic [TAG_W-1:0]   tag_arr  [SETS];
   logic [255:0]       data_arr [SETS];

   logic [TAG_W-1:0]   req_tag;
   logic [S_INDEX-1:0] idx;
   logic [2:0]         wsel;
   logic [7:0]         wbase;
   logic               req, hit, fill_done, store_upd;
   logic [31:0]        cur_word, merged_word;
   logic               unused_addr_bits;

   assign req_tag          = bus.mem_address[31 -: TAG_W];
   assign idx              = bus.mem_address[4+S_INDEX:5];
   assign wsel             = bus.mem_address[4:2];
   assign wbase            = {wsel, 5'b0};
   assign unused_addr_bits = ^bus.mem_address[1:0];

   assign req       = bus.mem_read | bus.mem_write;
   assign hit       = req & valid[idx] & (tag_arr[idx] == req_tag);
   assign cur_word  = data_arr[idx][wbase +: 32];
   assign fill_done = (state == FILL) & bus.pmem_resp;
   // mem_write wins over mem_read; an all-zero mask must not mark the line dirty
   assign store_upd = (state == IDLE) & hit & bus.mem_write & (|bus.mem_byte_enable);

   always_comb begin
      merged_word = cur_word;
      for (int unsigned i = 0; i < 4; i++) begin
         if (bus.mem_byte_enable[i]) merged_word[8*i +: 8] = bus.mem_wdata[8*i +: 8];
      end
   end

   always_comb begin
      state_next       = state;
      bus.mem_resp     = 1'b0;
      bus.mem_rdata    = '0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      unique case (state)
         IDLE: begin
            if (hit) begin
               bus.mem_resp  = 1'b1;
               bus.mem_rdata = cur_word;
            end else if (req) begin
               state_next = (valid[idx] & dirty[idx]) ? WRITEBACK : FILL;
            end
         end
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_arr[idx], idx, 5'b0};
            bus.pmem_wdata   = data_arr[idx];
            if (bus.pmem_resp) state_next = FILL;
         end
         FILL: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {req_tag, idx, 5'b0};
            if (bus.pmem_resp) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= state_next;
         if (fill_done) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
         end else if (store_upd) begin
            dirty[idx] <= 1'b1;
         end
      end
   end

   // Tag/data storage carries no reset; valid gates every use of it
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_arr[idx]  <= req_tag;
         data_arr[idx] <= bus.pmem_rdata;
      end else if (store_upd) begin
         data_arr[idx][wbase +: 32] <= merged_word;
      end
   end
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: fills, store hits, dirty/clean evictions,
// back-to-back hits and reset during a line fill.
module tb_dcache;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   dcache_if bus();

   dcache #(.S_INDEX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [255:0] mkline(input logic [31:0] base);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = base + w;
      return l;
   endfunction

   task automatic set_idle();
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      bus.mem_address = '0; bus.mem_wdata = '0; bus.mem_byte_enable = '0;
   endtask

   task automatic set_load(input logic [31:0] a);
      bus.mem_read = 1'b1; bus.mem_write = 1'b0;
      bus.mem_address = a; bus.mem_wdata = '0; bus.mem_byte_enable = '0;
   endtask

   task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic rd);
      bus.mem_read = rd; bus.mem_write = 1'b1;
      bus.mem_address = a; bus.mem_wdata = d; bus.mem_byte_enable = be;
   endtask

   // Plays the line memory for a pending miss; returns once mem_resp is seen (or a bound expires).
   task automatic serve_miss(input int lat_wb, input int lat_fill, input logic [255:0] fill,
                             output int n_wb, output int n_fill,
                             output logic [31:0] wb_a, output logic [31:0] fill_a,
                             output logic [255:0] wb_d, output int cyc,
                             output bit timeout, output bit both);
      int hold;
      n_wb = 0; n_fill = 0; wb_a = '0; fill_a = '0; wb_d = '0;
      cyc = 0; hold = 0; both = 1'b0;
      bus.pmem_resp = 1'b0;
      while (cyc < 100) begin
         @(negedge clk); #1;
         cyc++;
         bus.pmem_resp = 1'b0;
         if (bus.mem_resp === 1'b1) break;
         if (bus.pmem_read && bus.pmem_write) both = 1'b1;
         if (bus.pmem_write) begin
            n_wb++; wb_a = bus.pmem_address; wb_d = bus.pmem_wdata; hold++;
            if (hold >= lat_wb) begin bus.pmem_resp = 1'b1; hold = 0; end
         end else if (bus.pmem_read) begin
            n_fill++; fill_a = bus.pmem_address; hold++;
            if (hold >= lat_fill) begin bus.pmem_resp = 1'b1; bus.pmem_rdata = fill; hold = 0; end
         end
      end
      timeout = (bus.mem_resp !== 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_load(32'h0000_1004);
      bus.pmem_resp = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total++; if (bus.mem_resp !== 1'b0) begin bad++; $display("FAIL reset_mem_resp got=%0h want=0", bus.mem_resp); end
      total++; if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_mem_rdata got=%08h want=0", bus.mem_rdata); end
      total++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%0b%0b want=00", bus.pmem_read, bus.pmem_write); end
      total++; if (bus.pmem_address !== 32'h0) begin bad++; $display("FAIL reset_pmem_address got=%08h want=0", bus.pmem_address); end
      total++; if (bus.pmem_wdata !== 256'h0) begin bad++; $display("FAIL reset_pmem_wdata got=%064h want=0", bus.pmem_wdata); end
      set_idle();
      bus.pmem_resp = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_clean_miss();
      int n_wb, n_fill, cyc; bit to, both;
      logic [31:0] wb_a, fill_a; logic [255:0] wb_d;
      @(negedge clk);
      set_load(32'h0000_1004);
      #1;
      total++; if (bus.mem_resp !== 1'b0) begin bad++; $display("FAIL miss_resp_first got=%0h want=0", bus.mem_resp); end
      serve_miss(2, 2, mkline(32'hA5A5_0000), n_wb, n_fill, wb_a, fill_a, wb_d, cyc, to, both);
      total++; if (to) begin bad++; $display("FAIL miss_timeout got=%0d cycles want=mem_resp", cyc); end
      total++; if (n_wb != 0) begin bad++; $display("FAIL miss_no_wb got=%0d want=0", n_wb); end
      total++; if (fill_a !== 32'h0000_1000) begin bad++; $display("FAIL miss_fill_addr got=%08h want=00001000", fill_a); end
      total++; if (n_fill != 2 || cyc != 3) begin bad++; $display("FAIL miss_latency got=fill%0d/cyc%0d want=fill2/cyc3", n_fill, cyc); end
      total++; if (bus.mem_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL miss_rdata got=%08h want=a5a50001", bus.mem_rdata); end
   endtask

   task automatic test_store_hit();
      @(negedge clk);
      set_store(32'h0000_1008, 32'h0000_BE00, 4'b0010, 1'b0);
      #1;
      total++; if (bus.mem_resp !== 1'b1) begin bad++; $display("FAIL store_hit_resp got=%0h want=1", bus.mem_resp); end
      @(negedge clk);
      set_load(32'h0000_1008);
      #1;
      total++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hA5A5_BE02) begin bad++; $display("FAIL store_readback got=%0h/%08h want=1/a5a5be02", bus.mem_resp, bus.mem_rdata); end
   endtask

   task automatic test_dirty_evict();
      int n_wb, n_fill, cyc; bit to, both;
      logic [31:0] wb_a, fill_a; logic [255:0] wb_d, exp_line;
      exp_line = mkline(32'hA5A5_0000);
      exp_line[64 +: 32] = 32'hA5A5_BE02;
      @(negedge clk);
      set_load(32'h0000_1208);
      #1;
      total++; if (bus.mem_resp !== 1'b0) begin bad++; $display("FAIL dirty_resp_first got=%0h want=0", bus.mem_resp); end
      serve_miss(3, 2, mkline(32'h5A5A_0000), n_wb, n_fill, wb_a, fill_a, wb_d, cyc, to, both);
      total++; if (to) begin bad++; $display("FAIL dirty_timeout got=%0d cycles want=mem_resp", cyc); end
      total++; if (n_wb != 3 || wb_a !== 32'h0000_1000) begin bad++; $display("FAIL dirty_wb got=%0d@%08h want=3@00001000", n_wb, wb_a); end
      total++; if (wb_d !== exp_line) begin bad++; $display("FAIL dirty_wb_data got=%064h want=%064h", wb_d, exp_line); end
      total++; if (fill_a !== 32'h0000_1200) begin bad++; $display("FAIL dirty_fill_addr got=%08h want=00001200", fill_a); end
      total++; if (cyc != 6 || both) begin bad++; $display("FAIL dirty_latency got=cyc%0d/both%0b want=cyc6/both0", cyc, both); end
      total++; if (bus.mem_rdata !== 32'h5A5A_0002) begin bad++; $display("FAIL dirty_rdata got=%08h want=5a5a0002", bus.mem_rdata); end
   endtask

   task automatic test_clean_evict();
      int n_wb, n_fill, cyc; bit to, both;
      logic [31:0] wb_a, fill_a; logic [255:0] wb_d;
      @(negedge clk);
      set_load(32'h0000_2000);
      #1;
      serve_miss(2, 1, mkline(32'h3C3C_0000), n_wb, n_fill, wb_a, fill_a, wb_d, cyc, to, both);
      total++; if (to || n_wb != 0) begin bad++; $display("FAIL clean_evict_wb got=to%0b/wb%0d want=to0/wb0", to, n_wb); end
      total++; if (fill_a !== 32'h0000_2000 || cyc != 2) begin bad++; $display("FAIL clean_evict_fill got=%08h/cyc%0d want=00002000/cyc2", fill_a, cyc); end
      total++; if (bus.mem_rdata !== 32'h3C3C_0000) begin bad++; $display("FAIL clean_evict_rdata got=%08h want=3c3c0000", bus.mem_rdata); end
   endtask

   task automatic test_zero_mask();
      int n_wb, n_fill, cyc; bit to, both;
      logic [31:0] wb_a, fill_a; logic [255:0] wb_d;
      @(negedge clk);
      set_store(32'h0000_2004, 32'hFFFF_FFFF, 4'b0000, 1'b0);
      #1;
      total++; if (bus.mem_resp !== 1'b1) begin bad++; $display("FAIL zmask_resp got=%0h want=1", bus.mem_resp); end
      @(negedge clk);
      set_load(32'h0000_2004);
      #1;
      total++; if (bus.mem_rdata !== 32'h3C3C_0001) begin bad++; $display("FAIL zmask_data got=%08h want=3c3c0001", bus.mem_rdata); end
      @(negedge clk);
      set_load(32'h0000_1000);
      #1;
      serve_miss(1, 1, mkline(32'hA5A5_0000), n_wb, n_fill, wb_a, fill_a, wb_d, cyc, to, both);
      total++; if (to || n_wb != 0 || fill_a !== 32'h0000_1000) begin bad++; $display("FAIL zmask_evict got=wb%0d/%08h want=wb0/00001000", n_wb, fill_a); end
      total++; if (bus.mem_rdata !== 32'hA5A5_0000) begin bad++; $display("FAIL zmask_refill_rdata got=%08h want=a5a50000", bus.mem_rdata); end
   endtask

   task automatic test_back_to_back();
      int n_wb, n_fill, cyc; bit to, both;
      logic [31:0] wb_a, fill_a; logic [255:0] wb_d;
      logic [31:0] addrs [3] = '{32'h0000_100C, 32'h0000_1034, 32'h0000_101C};
      logic [31:0] exps  [3] = '{32'hA5A5_0003, 32'h7E7E_0005, 32'hA5A5_0007};
      @(negedge clk);
      set_load(32'h0000_1020);
      #1;
      serve_miss(1, 2, mkline(32'h7E7E_0000), n_wb, n_fill, wb_a, fill_a, wb_d, cyc, to, both);
      total++; if (to || bus.mem_rdata !== 32'h7E7E_0000) begin bad++; $display("FAIL b2b_fill got=%08h want=7e7e0000", bus.mem_rdata); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         set_load(addrs[i]);
         #1;
         total++;
         if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== exps[i] || bus.pmem_read !== 1'b0) begin
            bad++; $display("FAIL b2b_hit%0d got=%0h/%08h/%0h want=1/%08h/0", i, bus.mem_resp, bus.mem_rdata, bus.pmem_read, exps[i]);
         end
      end
      @(negedge clk);
      set_idle();
      bus.pmem_resp = 1'b1;
      #1;
      total++; if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL noreq got=%0h/%08h want=0/00000000", bus.mem_resp, bus.mem_rdata); end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1;
      total++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin bad++; $display("FAIL idle_pmem_resp got=%0b%0b want=00", bus.pmem_read, bus.pmem_write); end
   endtask

   task automatic test_merge();
      int n_wb, n_fill, cyc; bit to, both;
      logic [31:0] wb_a, fill_a; logic [255:0] wb_d, exp_line;
      exp_line = mkline(32'h7E7E_0000);
      exp_line[64 +: 32] = 32'h117E_0044;
      exp_line[96 +: 32] = 32'hCAFE_F00D;
      @(negedge clk);
      set_store(32'h0000_1028, 32'h1122_3344, 4'b1001, 1'b0);
      #1;
      total++; if (bus.mem_resp !== 1'b1) begin bad++; $display("FAIL merge_store_resp got=%0h want=1", bus.mem_resp); end
      @(negedge clk);
      set_load(32'h0000_1028);
      #1;
      total++; if (bus.mem_rdata !== 32'h117E_0044) begin bad++; $display("FAIL merge_readback got=%08h want=117e0044", bus.mem_rdata); end
      @(negedge clk);
      set_store(32'h0000_102C, 32'hCAFE_F00D, 4'b1111, 1'b1);
      #1;
      total++; if (bus.mem_resp !== 1'b1) begin bad++; $display("FAIL rw_store_resp got=%0h want=1", bus.mem_resp); end
      @(negedge clk);
      set_load(32'h0000_102C);
      #1;
      total++; if (bus.mem_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rw_readback got=%08h want=cafef00d", bus.mem_rdata); end
      @(negedge clk);
      set_load(32'h0000_3020);
      #1;
      serve_miss(3, 2, mkline(32'h0F0F_0000), n_wb, n_fill, wb_a, fill_a, wb_d, cyc, to, both);
      total++; if (to || n_wb != 3 || wb_a !== 32'h0000_1020) begin bad++; $display("FAIL merge_wb got=wb%0d@%08h want=wb3@00001020", n_wb, wb_a); end
      total++; if (wb_d !== exp_line) begin bad++; $display("FAIL merge_wb_data got=%064h want=%064h", wb_d, exp_line); end
      total++; if (fill_a !== 32'h0000_3020 || cyc != 6 || bus.mem_rdata !== 32'h0F0F_0000) begin bad++; $display("FAIL merge_refill got=%08h/cyc%0d/%08h want=00003020/cyc6/0f0f0000", fill_a, cyc, bus.mem_rdata); end
   endtask

   task automatic test_reset_mid_fill();
      int n_wb, n_fill, cyc; bit to, both;
      logic [31:0] wb_a, fill_a; logic [255:0] wb_d;
      @(negedge clk);
      set_load(32'h0000_1040);
      @(negedge clk);
      #1;
      total++; if (bus.pmem_read !== 1'b1) begin bad++; $display("FAIL rmf_fill_start got=%0h want=1", bus.pmem_read); end
      rst = 1'b0;
      #1;
      total++; if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'h0) begin bad++; $display("FAIL rmf_async_drop got=%0h/%08h want=0/00000000", bus.pmem_read, bus.pmem_address); end
      set_idle();
      @(negedge clk);
      rst = 1'b1;
      bus.pmem_resp = 1'b1;
      bus.pmem_rdata = mkline(32'hDEAD_0000);
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1;
      total++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin bad++; $display("FAIL rmf_late_resp got=%0b%0b want=00", bus.pmem_read, bus.pmem_write); end
      set_load(32'h0000_1040);
      #1;
      total++; if (bus.mem_resp !== 1'b0) begin bad++; $display("FAIL rmf_remiss got=%0h want=0", bus.mem_resp); end
      serve_miss(1, 1, mkline(32'h4444_0000), n_wb, n_fill, wb_a, fill_a, wb_d, cyc, to, both);
      total++; if (to || n_wb != 0 || fill_a !== 32'h0000_1040 || bus.mem_rdata !== 32'h4444_0000) begin bad++; $display("FAIL rmf_refill got=wb%0d/%08h/%08h want=wb0/00001040/44440000", n_wb, fill_a, bus.mem_rdata); end
      @(negedge clk);
      set_load(32'h0000_1000);
      #1;
      total++; if (bus.mem_resp !== 1'b0) begin bad++; $display("FAIL rmf_empty_after_reset got=%0h want=0", bus.mem_resp); end
      serve_miss(1, 1, mkline(32'hA5A5_0000), n_wb, n_fill, wb_a, fill_a, wb_d, cyc, to, both);
      total++; if (to || fill_a !== 32'h0000_1000 || bus.mem_rdata !== 32'hA5A5_0000) begin bad++; $display("FAIL rmf_refill0 got=%08h/%08h want=00001000/a5a50000", fill_a, bus.mem_rdata); end
      @(negedge clk);
      set_idle();
   endtask

   initial begin
      rst = 1'b0;
      set_idle();
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      test_reset();
      test_clean_miss();
      test_store_hit();
      test_dirty_evict();
      test_clean_evict();
      test_zero_mask();
      test_back_to_back();
      test_merge();
      test_reset_mid_fill();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
